// File: rtl/ddr5_phy_crc_check.sv
// ddr5_phy_crc_check
// Read-path CRC-8 checker for the DDR5 PHY. Accumulates one CRC-8 (poly 0x07,
// init 0x00, no reflection, no final XOR) per x4 nibble over the 8 data slices
// of a burst, then compares against the trailer slice. It reports per-nibble
// mismatch flags and keeps a saturating count of failing bursts.
module ddr5_phy_crc_check #(
   parameter int          pDRAM_SIZE   = 4,
   // Saturation ceiling of the error counter; normally the full 16-bit range.
   parameter logic [15:0] pERR_CNT_MAX = 16'hFFFF
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      crc_en_i,
   input  logic [2*pDRAM_SIZE-1:0]   crc_in_data_i,
   input  logic                      crc_flush_i,
   input  logic                      crc_err_clr_i,
   output logic                      crc_busy_o,
   output logic                      crc_done_o,
   output logic                      crc_err_o,
   output logic [pDRAM_SIZE/4-1:0]   crc_err_lane_o,
   output logic [15:0]               crc_err_cnt_o
);

   localparam int N = pDRAM_SIZE / 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_CRC  = 2'd2;

   // One byte step of the CRC-8, bit 7 of the data byte processed first.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
      logic [7:0] c;
      c = crc ^ d;
      for (int i = 0; i < 8; i++) begin
         c = {c[6:0], 1'b0} ^ (c[7] ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   logic [1:0]     state_r,  state_nxt_s;
   logic [2:0]     dcnt_r,   dcnt_nxt_s;
   logic [8*N-1:0] crc_r,    crc_nxt_s;
   logic           busy_r;
   logic           done_r,   done_nxt_s;
   logic           err_r,    err_nxt_s;
   logic [N-1:0]   lane_r,   lane_nxt_s;
   logic [15:0]    cnt_r,    cnt_nxt_s, cnt_base_s;
   logic [8*N-1:0] step_s;
   logic [N-1:0]   mis_s;

   // Per-nibble byte step of the accumulator and trailer comparison.
   always_comb begin
      step_s = {(8*N){1'b0}};
      mis_s  = {N{1'b0}};
      for (int k = 0; k < N; k++) begin
         if (state_r == ST_IDLE) begin
            step_s[8*k +: 8] = crc8_step(8'h00, crc_in_data_i[8*k +: 8]);
         end else begin
            step_s[8*k +: 8] = crc8_step(crc_r[8*k +: 8], crc_in_data_i[8*k +: 8]);
         end
         mis_s[k] = (crc_r[8*k +: 8] != crc_in_data_i[8*k +: 8]);
      end
   end

   // Burst sequencing: IDLE -> DATA (8 slices) -> CRC compare; flush aborts.
   always_comb begin
      state_nxt_s = state_r;
      dcnt_nxt_s  = dcnt_r;
      crc_nxt_s   = crc_r;
      done_nxt_s  = 1'b0;
      lane_nxt_s  = lane_r;
      err_nxt_s   = err_r;
      if (crc_flush_i) begin
         state_nxt_s = ST_IDLE;
         dcnt_nxt_s  = 3'd0;
         crc_nxt_s   = {(8*N){1'b0}};
      end else if (crc_en_i) begin
         case (state_r)
            ST_IDLE: begin
               crc_nxt_s   = step_s;
               dcnt_nxt_s  = 3'd1;
               state_nxt_s = ST_DATA;
            end
            ST_DATA: begin
               crc_nxt_s  = step_s;
               dcnt_nxt_s = dcnt_r + 3'd1;
               if (dcnt_r == 3'd7) begin
                  state_nxt_s = ST_CRC;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end
            ST_CRC: begin
               lane_nxt_s  = mis_s;
               err_nxt_s   = |mis_s;
               done_nxt_s  = 1'b1;
               state_nxt_s = ST_IDLE;
               dcnt_nxt_s  = 3'd0;
               // Clearing here keeps IDLE's accumulator at the initial value.
               crc_nxt_s   = {(8*N){1'b0}};
            end
            default: begin
               state_nxt_s = ST_IDLE;
               dcnt_nxt_s  = 3'd0;
               crc_nxt_s   = {(8*N){1'b0}};
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Error counter: clear first, then a failing done increments (saturating).
   always_comb begin
      cnt_base_s = crc_err_clr_i ? 16'h0000 : cnt_r;
      if (done_nxt_s && err_nxt_s && (cnt_base_s != pERR_CNT_MAX)) begin
         cnt_nxt_s = cnt_base_s + 16'd1;
      end else begin
         cnt_nxt_s = cnt_base_s;
      end
   end

   // State, accumulator and registered status outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r <= ST_IDLE;
         dcnt_r  <= 3'd0;
         crc_r   <= {(8*N){1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         lane_r  <= {N{1'b0}};
         cnt_r   <= 16'h0000;
      end else begin
         state_r <= state_nxt_s;
         dcnt_r  <= dcnt_nxt_s;
         crc_r   <= crc_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         done_r  <= done_nxt_s;
         err_r   <= err_nxt_s;
         lane_r  <= lane_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign crc_busy_o     = busy_r;
   assign crc_done_o     = done_r;
   assign crc_err_o      = err_r;
   assign crc_err_lane_o = lane_r;
   assign crc_err_cnt_o  = cnt_r;

endmodule

// File: doc/ddr5_phy_crc_check.md
# ddr5_phy_crc_check

Read-path CRC checker for the DDR5 PHY, the receive-side counterpart of the write-path CRC generator. It accepts read data from the read data block two beats per clock and accumulates a CRC-8 per x4 nibble over each 16-beat burst. It then compares the result against the 2-beat CRC trailer and reports a per-nibble pass/fail plus a saturating error count to the PHY status logic.

## Interface
- pDRAM_SIZE, default 4: device width (4, 8 or 16); nibble count N = pDRAM_SIZE/4.
- clk_i  input  1  PHY clock; all logic on the rising edge.
- rst_n_i  input  1  reset, asynchronous and active-low.
- crc_en_i  input  1  slice valid from the read data block; gaps between valid cycles are allowed.
- crc_in_data_i  input  2*pDRAM_SIZE  two beats per cycle. Nibble k uses slice [8k+7:8k]: [8k+3:8k] is the even beat on DQ[4k+3:4k], [8k+7:8k+4] is the odd beat.
- crc_flush_i  input  1  synchronous abort of the current burst.
- crc_err_clr_i  input  1  synchronous clear of the error counter.
- crc_busy_o  output  1  burst in progress (state != IDLE).
- crc_done_o  output  1  one-cycle pulse when a check result is valid.
- crc_err_o  output  1  OR of crc_err_lane_o; meaningful only while crc_done_o=1.
- crc_err_lane_o  output  N  per-nibble mismatch flags, held until the next done pulse.
- crc_err_cnt_o  output  16  count of bursts with crc_err_o=1, saturating at 0xFFFF.

## Operation
- Burst format: 9 valid cycles. Valid cycles 0..7 carry data (16 beats). Valid cycle 8 carries the CRC trailer, and nibble k's slice equals its expected CRC[7:0].
- CRC definition, identical to the write-path generator: polynomial x^8+x^2+x+1 (0x07), initial value 0x00, no reflection, no final XOR.
- Per data cycle, each nibble's slice is taken as byte d with bit 7 processed first: crc = crc ^ d, then 8 times crc = {crc[6:0],1'b0} ^ (crc[7] ? 0x07 : 0x00). This is one combinational byte step per cycle per nibble.
- FSM states: IDLE, DATA, CRC. A 3-bit data counter tracks progress.
  - IDLE with crc_en_i=1: the CRC registers load step(0x00, slice), counter=1, go to DATA.
  - DATA with crc_en_i=1: the CRC registers update and the counter increments. When the 8th data slice is consumed (counter was 7), go to CRC.
  - CRC with crc_en_i=1: compare each nibble's accumulated CRC with its slice, register the flags, pulse done, go to IDLE.
  - In any state, crc_en_i=0 holds all state.
- Counter increments by 1 on each done pulse with crc_err_o=1, and saturates at 0xFFFF.
- crc_flush_i=1: go to IDLE, reset the data counter and CRC registers to 0, with no done pulse. The slice presented in the same cycle is discarded. Error flags and the counter are unchanged.
- crc_err_clr_i and an error-counting done in the same cycle: clear takes priority, then the increment applies, so the counter becomes 1.
- Back-to-back bursts: the first data slice of the next burst may arrive the cycle after the CRC slice. IDLE accepts it with no bubble.

## Timing
- Reset values: crc_busy_o=0, crc_done_o=0, crc_err_o=0, crc_err_lane_o=0, crc_err_cnt_o=0. The FSM is in IDLE and the CRC registers are 0x00.
- Latency: crc_done_o, crc_err_o and crc_err_lane_o are registered. They assert in the cycle after the edge that samples the CRC slice, which is 1 cycle after the CRC slice is presented.
- crc_err_cnt_o updates on the same edge that raises crc_done_o.
- crc_busy_o rises the cycle after the first data slice is sampled. It falls on the same edge that raises crc_done_o.
- Reset asserted mid-burst: all state clears immediately, and the partial burst produces no done pulse.
- Throughput: one burst per 9 valid cycles, sustained.

## Test plan
- x4, 8 data slices 0x00 then CRC slice 0x00 -> done pulse 1 cycle later, crc_err_o=0, crc_err_lane_o=0, counter stays 0.
- x4, 8 data slices 0xFF then CRC slice 0xD7 -> pass. Repeat with CRC slice 0xD6 -> crc_err_o=1, lane=1'b1, counter=1.
- x16, nibbles 0..3 carry 0xFF data with CRC 0xD7, except nibble 2 whose CRC slice is 0x00 -> crc_err_lane_o=4'b0100, crc_err_o=1.
- Burst with 3 idle cycles between slices, immediately followed by a back-to-back second burst -> two correct results. crc_busy_o drops only for the done cycle.
- crc_flush_i asserted after 5 data slices, then a full good burst -> no done from the aborted burst, and the good burst passes.
- Force the counter to 0xFFFF by repeated bad bursts, then one more bad burst -> stays 0xFFFF. Then assert crc_err_clr_i coincident with a bad-burst done -> counter=1.
